// File: rtl/fir_post_pkg.sv
// rtl/fir_post_pkg.sv - shared state type, widths and shift/round/saturate arithmetic for fir_post_decim
package fir_post_pkg;

    localparam int P_DATA_WIDTH = 32;
    localparam int P_OUT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [P_OUT_WIDTH-1:0] P_SAT_MAX = {1'b0, {(P_OUT_WIDTH-1){1'b1}}};
    localparam logic [P_OUT_WIDTH-1:0] P_SAT_MIN = {1'b1, {(P_OUT_WIDTH-1){1'b0}}};

    // Bounds sign-extended to the one-bit-wider working width used for rounding
    localparam logic signed [P_DATA_WIDTH:0] P_SAT_MAX_X =
        {{(P_DATA_WIDTH-P_OUT_WIDTH+1){1'b0}}, P_SAT_MAX};
    localparam logic signed [P_DATA_WIDTH:0] P_SAT_MIN_X =
        {{(P_DATA_WIDTH-P_OUT_WIDTH+1){1'b1}}, P_SAT_MIN};

    typedef struct packed {
        logic                   sat;
        logic [P_OUT_WIDTH-1:0] data;
    } srs_t;

    function automatic srs_t shift_round_sat(input logic [P_DATA_WIDTH-1:0] x,
                                             input logic [4:0]              s);
        logic signed [P_DATA_WIDTH:0] v;
        srs_t                         r;
        v = {x[P_DATA_WIDTH-1], x};
        if (s != 5'd0) begin
            v = v + ((P_DATA_WIDTH+1)'(1) << (s - 5'd1));
        end
        v = v >>> s;
        if (v > P_SAT_MAX_X) begin
            r.sat  = 1'b1;
            r.data = P_SAT_MAX;
        end else if (v < P_SAT_MIN_X) begin
            r.sat  = 1'b1;
            r.data = P_SAT_MIN;
        end else begin
            r.sat  = 1'b0;
            r.data = v[P_OUT_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - synchronous FIFO with register-array head and occupancy count
module axis_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is dropped even if a pop frees a slot this cycle
    assign push_ok   = push && (count != FULL_CNT);
    assign pop_ok    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_post_decim.sv
// rtl/fir_post_decim.sv - FIR output post-processing: round/shift/saturate, decimate, buffer, count
module fir_post_decim
    import fir_post_pkg::*;
#(
    parameter int pDATA_WIDTH = P_DATA_WIDTH,
    parameter int pOUT_WIDTH  = P_OUT_WIDTH,
    parameter int pFIFO_DEPTH = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic [4:0]             cfg_shift,
    input  logic [3:0]             cfg_decim,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pOUT_WIDTH-1:0]  sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    output logic                   busy,
    output logic [31:0]            stat_in_cnt,
    output logic [31:0]            stat_out_cnt,
    output logic [31:0]            stat_sat_cnt
);
    localparam int CW = $clog2(pFIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(pFIFO_DEPTH);

    state_t          state;
    logic [4:0]      shift_q;
    logic [3:0]      decim_q;
    logic [3:0]      phase;
    logic [4:0]      cur_shift;
    logic [3:0]      cur_decim;
    logic [3:0]      cur_phase;
    logic [3:0]      next_phase;
    logic            accept;
    logic            keep;
    logic            push;
    logic            pop;
    srs_t            res;
    logic [CW-1:0]   fifo_count;
    logic [pOUT_WIDTH:0] fifo_head;

    assign ss_tready = !axis_rst && (state != ST_DRAIN) && (fifo_count != FULL_CNT);
    assign sm_tvalid = (fifo_count != '0);
    assign sm_tdata  = fifo_head[pOUT_WIDTH:1];
    assign sm_tlast  = fifo_head[0];
    assign accept    = ss_tvalid && ss_tready;
    assign pop       = sm_tvalid && sm_tready;

    // The first beat of a frame is processed with the live config it latches
    always_comb begin
        cur_shift = shift_q;
        cur_decim = decim_q;
        cur_phase = phase;
        if (state == ST_IDLE) begin
            cur_shift = cfg_shift;
            cur_decim = (cfg_decim == 4'd0) ? 4'd1 : cfg_decim;
            cur_phase = 4'd0;
        end
        next_phase = (cur_phase == cur_decim - 4'd1) ? 4'd0 : cur_phase + 4'd1;
        keep       = (cur_phase == 4'd0) || ss_tlast;
        push       = accept && keep;
        res        = shift_round_sat(ss_tdata, cur_shift);
    end

    axis_sync_fifo #(
        .WIDTH (pOUT_WIDTH + 1),
        .DEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk       (axis_clk),
        .rst       (axis_rst),
        .push      (push),
        .push_data ({res.data, ss_tlast}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            shift_q      <= 5'd0;
            decim_q      <= 4'd1;
            phase        <= 4'd0;
            stat_in_cnt  <= 32'd0;
            stat_out_cnt <= 32'd0;
            stat_sat_cnt <= 32'd0;
        end else begin
            if (accept) begin
                stat_in_cnt <= stat_in_cnt + 32'd1;
            end
            if (push && res.sat) begin
                stat_sat_cnt <= stat_sat_cnt + 32'd1;
            end
            if (pop) begin
                stat_out_cnt <= stat_out_cnt + 32'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q <= cur_shift;
                        decim_q <= cur_decim;
                        phase   <= next_phase;
                        busy    <= 1'b1;
                        state   <= ss_tlast ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        phase <= next_phase;
                        if (ss_tlast) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_count == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_post_decim.sv
// tb/tb_fir_post_decim.sv - self-checking bench for fir_post_decim
module tb_fir_post_decim;

    logic        axis_clk  = 1'b0;
    logic        axis_rst  = 1'b1;
    logic [4:0]  cfg_shift = 5'd0;
    logic [3:0]  cfg_decim = 4'd1;
    logic        ss_tvalid = 1'b0;
    logic [31:0] ss_tdata  = 32'd0;
    logic        ss_tlast  = 1'b0;
    logic        ss_tready;
    logic        sm_tvalid;
    logic [15:0] sm_tdata;
    logic        sm_tlast;
    logic        sm_tready = 1'b1;
    logic        busy;
    logic [31:0] stat_in_cnt;
    logic [31:0] stat_out_cnt;
    logic [31:0] stat_sat_cnt;

    always #5 axis_clk = ~axis_clk;

    fir_post_decim dut (
        .axis_clk     (axis_clk),
        .axis_rst     (axis_rst),
        .cfg_shift    (cfg_shift),
        .cfg_decim    (cfg_decim),
        .ss_tvalid    (ss_tvalid),
        .ss_tdata     (ss_tdata),
        .ss_tlast     (ss_tlast),
        .ss_tready    (ss_tready),
        .sm_tvalid    (sm_tvalid),
        .sm_tdata     (sm_tdata),
        .sm_tlast     (sm_tlast),
        .sm_tready    (sm_tready),
        .busy         (busy),
        .stat_in_cnt  (stat_in_cnt),
        .stat_out_cnt (stat_out_cnt),
        .stat_sat_cnt (stat_sat_cnt)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       got[$];
    int          n_err    = 0;
    int          n_checks = 0;
    int          ex[8];
    logic        m_run    = 1'b0;
    logic        m_drain  = 1'b0;
    int          f_shift  = 0;
    int          f_decim  = 1;
    int          m_idx    = 0;
    logic [31:0] m_in     = 32'd0;
    logic [31:0] m_out    = 32'd0;
    logic [31:0] m_sat    = 32'd0;
    logic [31:0] base_in;
    logic [31:0] base_out;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Frame-level model: occupancy queue, per-frame config, beat index within frame
    always @(negedge axis_clk) begin
        if (axis_rst) begin
            exp_q.delete();
            m_run   = 1'b0;
            m_drain = 1'b0;
            m_in    = 32'd0;
            m_out   = 32'd0;
            m_sat   = 32'd0;
        end else begin : mon_blk
            logic   exp_ready;
            logic   do_pop;
            logic   do_acc;
            logic   drain_exit;
            logic   keep;
            logic   sat;
            longint v;
            beat_t  b;
            exp_ready = !m_drain && (exp_q.size() != 4);
            chk("ss_tready", ss_tready, exp_ready);
            chk("sm_tvalid", sm_tvalid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("sm_tdata", sm_tdata, exp_q[0].d);
                chk("sm_tlast", sm_tlast, exp_q[0].l);
            end
            chk("busy", busy, m_run || m_drain);
            chk("stat_in_cnt", stat_in_cnt, m_in);
            chk("stat_out_cnt", stat_out_cnt, m_out);
            chk("stat_sat_cnt", stat_sat_cnt, m_sat);

            if (sm_tvalid && sm_tready) begin
                b.d = sm_tdata;
                b.l = sm_tlast;
                got.push_back(b);
            end

            do_pop     = (exp_q.size() != 0) && sm_tready;
            do_acc     = ss_tvalid && exp_ready;
            drain_exit = m_drain && (exp_q.size() == 0);
            if (do_pop) begin
                void'(exp_q.pop_front());
                m_out++;
            end
            if (do_acc) begin
                if (!m_run && !m_drain) begin
                    f_shift = int'(cfg_shift);
                    f_decim = (cfg_decim == 4'd0) ? 1 : int'(cfg_decim);
                    m_idx   = 0;
                end
                keep = ((m_idx % f_decim) == 0) || ss_tlast;
                v = longint'($signed(ss_tdata));
                if (f_shift > 0) v = v + (longint'(1) << (f_shift - 1));
                v = v >>> f_shift;
                sat = 1'b0;
                if (v > 32767) begin
                    v = 32767;
                    sat = 1'b1;
                end else if (v < -32768) begin
                    v = -32768;
                    sat = 1'b1;
                end
                if (keep) begin
                    b.d = v[15:0];
                    b.l = ss_tlast;
                    exp_q.push_back(b);
                    if (sat) m_sat++;
                end
                m_in++;
                m_idx++;
                if (ss_tlast) begin
                    m_run   = 1'b0;
                    m_drain = 1'b1;
                end else begin
                    m_run = 1'b1;
                end
            end
            if (drain_exit) m_drain = 1'b0;
        end
    end

    task automatic send_beat(input int d, input bit l);
        int n;
        n = 0;
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = l;
        @(negedge axis_clk);
        while (!ss_tready && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        if (!ss_tready) chk("send accept", ss_tready, 1);
        @(posedge axis_clk);
        #1;
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge axis_clk);
            n++;
        end while ((busy || sm_tvalid) && n < 300);
        chk({name, " idle"}, busy, 0);
        @(posedge axis_clk);
        #1;
    endtask

    task automatic check_got(input string name, input int n);
        chk({name, " count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk($sformatf("%s[%0d] data", name, i), longint'($signed(got[i].d)), ex[i]);
            chk($sformatf("%s[%0d] last", name, i), got[i].l, (i == n - 1) ? 1 : 0);
        end
        got.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge axis_clk);
        #1;
        chk("ready in reset", ss_tready, 0);
        axis_rst = 1'b0;
        @(negedge axis_clk);
        chk("reset ss_tready", ss_tready, 1);
        chk("reset sm_tvalid", sm_tvalid, 0);
        chk("reset sm_tdata", sm_tdata, 0);
        chk("reset sm_tlast", sm_tlast, 0);
        chk("reset busy", busy, 0);
        chk("reset stat_in", stat_in_cnt, 0);
        @(posedge axis_clk);
        #1;

        // Saturation at both rails
        cfg_shift = 5'd0;
        cfg_decim = 4'd1;
        send_beat(100, 0);
        send_beat(-5, 0);
        send_beat(70000, 0);
        send_beat(-70000, 1);
        wait_done("t1");
        ex = '{100, -5, 32767, -32768, 0, 0, 0, 0};
        check_got("t1", 4);
        chk("t1 sat", stat_sat_cnt, 2);
        chk("t1 in", stat_in_cnt, 4);
        chk("t1 out", stat_out_cnt, 4);

        // Round half up with shift 4
        cfg_shift = 5'd4;
        send_beat(24, 0);
        send_beat(-24, 0);
        send_beat(8, 0);
        send_beat(-9, 1);
        wait_done("t2");
        ex = '{2, -1, 1, -1, 0, 0, 0, 0};
        check_got("t2", 4);

        // Decimate by 3, tlast beat always kept
        cfg_shift = 5'd0;
        cfg_decim = 4'd3;
        base_in   = stat_in_cnt;
        base_out  = stat_out_cnt;
        for (int i = 1; i <= 8; i++) send_beat(i, i == 8);
        wait_done("t3");
        ex = '{1, 4, 7, 8, 0, 0, 0, 0};
        check_got("t3", 4);
        chk("t3 in", stat_in_cnt - base_in, 8);
        chk("t3 out", stat_out_cnt - base_out, 4);

        // Backpressure fills the FIFO
        cfg_decim = 4'd1;
        sm_tready = 1'b0;
        base_in   = stat_in_cnt;
        fork
            begin
                for (int k = 0; k < 6; k++) send_beat(10 + k, k == 5);
            end
        join_none
        repeat (10) @(negedge axis_clk);
        chk("bp accepted", stat_in_cnt - base_in, 4);
        chk("bp ready", ss_tready, 0);
        @(posedge axis_clk);
        #1;
        sm_tready = 1'b1;
        wait_done("bp");
        ex = '{10, 11, 12, 13, 14, 15, 0, 0};
        check_got("bp", 6);

        // Mid-frame config change is ignored until the next frame
        cfg_shift = 5'd0;
        send_beat(1000, 0);
        send_beat(2000, 0);
        cfg_shift = 5'd4;
        send_beat(3000, 0);
        send_beat(4000, 1);
        begin
            int n;
            n = 0;
            do begin
                @(negedge axis_clk);
                n++;
            end while (!(sm_tvalid && sm_tlast && sm_tready) && n < 50);
            chk("t5 last seen", sm_tlast, 1);
            @(negedge axis_clk);
            chk("t5 busy after pop", busy, 1);
            @(negedge axis_clk);
            chk("t5 busy idle", busy, 0);
        end
        wait_done("t5a");
        ex = '{1000, 2000, 3000, 4000, 0, 0, 0, 0};
        check_got("t5a", 4);
        send_beat(1000, 0);
        send_beat(2000, 0);
        send_beat(3000, 0);
        send_beat(4000, 1);
        wait_done("t5b");
        ex = '{63, 125, 188, 250, 0, 0, 0, 0};
        check_got("t5b", 4);

        // Reset in the middle of a frame
        cfg_shift = 5'd0;
        sm_tready = 1'b0;
        send_beat(1, 0);
        send_beat(2, 0);
        send_beat(3, 0);
        chk("pre-reset valid", sm_tvalid, 1);
        axis_rst = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        chk("mid reset ready", ss_tready, 0);
        axis_rst = 1'b0;
        @(negedge axis_clk);
        chk("rst sm_tvalid", sm_tvalid, 0);
        chk("rst stat_in", stat_in_cnt, 0);
        chk("rst stat_out", stat_out_cnt, 0);
        chk("rst stat_sat", stat_sat_cnt, 0);
        chk("rst busy", busy, 0);
        got.delete();
        @(posedge axis_clk);
        #1;
        sm_tready = 1'b1;
        cfg_decim = 4'd2;
        send_beat(5, 0);
        send_beat(6, 0);
        send_beat(7, 1);
        wait_done("t6");
        ex = '{5, 7, 0, 0, 0, 0, 0, 0};
        check_got("t6", 2);
        chk("t6 in", stat_in_cnt, 3);
        chk("t6 out", stat_out_cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_post_decim.md
# fir_post_decim

Downstream post-processing stage for the FIR engine's output stream. Consumes the FIR's 32-bit signed AXI-stream results, applies round-half-up arithmetic right shift and saturation to a narrower width, and decimates by a configurable factor. Results are buffered in a small output FIFO toward the next consumer. Running statistics counters are exposed for host readback.

## Interface
- pDATA_WIDTH, 32, input sample width (two's complement)
- pOUT_WIDTH, 16, output sample width after shift/saturate
- pFIFO_DEPTH, 4, output FIFO entries (power of two)

- axis_clk  in  1  sole clock, all logic on rising edge
- axis_rst  in  1  reset, synchronous, active-high
- cfg_shift  in  5  right-shift amount 0..31, latched at frame start
- cfg_decim  in  4  decimation factor D (0 treated as 1), latched at frame start
- ss_tvalid  in  1  input beat valid (driven by FIR sm_tvalid)
- ss_tdata  in  pDATA_WIDTH  signed FIR result
- ss_tlast  in  1  last beat of frame
- ss_tready  out  1  input accept
- sm_tvalid  out  1  output beat valid
- sm_tdata  out  pOUT_WIDTH  processed sample
- sm_tlast  out  1  last output beat of frame
- sm_tready  in  1  downstream accept
- busy  out  1  state != IDLE
- stat_in_cnt  out  32  input beats accepted since reset
- stat_out_cnt  out  32  output beats transferred since reset
- stat_sat_cnt  out  32  samples that saturated (kept samples only)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: ss_tready = FIFO not full. First accepted beat latches cfg_shift/cfg_decim into shadow registers, resets phase to 0, goes to RUN (or DRAIN if that beat has tlast).
- RUN: ss_tready = FIFO not full. Accepted beat with tlast -> DRAIN.
- DRAIN: ss_tready = 0; when FIFO empty -> IDLE.
- Config input changes during RUN/DRAIN are ignored until next IDLE->RUN.
- Arithmetic, per accepted beat x: extend x to pDATA_WIDTH+1 bits; add 2^(s-1) if s>0; arithmetic shift right by s; saturate to [-2^(pOUT_WIDTH-1), 2^(pOUT_WIDTH-1)-1]. Set sat flag if clamped.
- Decimation: phase counter 0..D-1, increments per accepted beat and wraps. Beat kept iff phase==0 or tlast. Tlast beat always kept, carries sm_tlast=1.
- Kept beats push {data, last} into FIFO. Dropped beats only increment stat_in_cnt.
- Counters wrap at 2^32. stat_sat_cnt increments only on kept, clamped beats.

## Timing
- Reset values: ss_tready 0 during reset, 1 on first cycle after (FIFO empty); sm_tvalid 0, sm_tdata 0, sm_tlast 0, busy 0, all stat counters 0, state IDLE, phase 0.
- Latency: beat accepted at edge N appears with sm_tvalid=1 after edge N (one-cycle latency, no combinational ss->sm path).
- sm_tvalid = FIFO not empty; sm_tdata/sm_tlast = FIFO head, registered. Stable while sm_tvalid && !sm_tready.
- Full: ss_tready=0 when count==pFIFO_DEPTH, even if a pop occurs that cycle (no same-cycle bypass).
- Simultaneous push and pop with 0<count<depth: count unchanged, order preserved.
- Empty: sm_tvalid=0. FIFO pointers wrap modulo pFIFO_DEPTH.
- Reset mid-frame: FIFO flushed, state IDLE, partial frame discarded, counters cleared.
- Throughput: one beat/cycle sustained when sm_tready held high.

## Structure
- Package fir_post_pkg: state enum (IDLE/RUN/DRAIN), saturation bounds derived from pOUT_WIDTH, and a shift-round-saturate function.
- Sub-module axis_sync_fifo (data + last, parameterised width/depth, count output) instantiated once. The FSM, decimation phase, arithmetic and counters stay in the top.

## Test plan
- shift=0, D=1, inputs 100, -5, 70000, -70000(last) -> outputs 100, -5, 32767, -32768(tlast). stat_sat_cnt=2, stat_in_cnt=stat_out_cnt=4.
- shift=4, D=1, inputs 24, -24, 8, -9(last) -> 2, -1, 1, -1(tlast).
- shift=0, D=3, inputs 1..8, tlast on 8 -> outputs 1, 4, 7, 8(tlast). stat_in_cnt=8, stat_out_cnt=4.
- Backpressure: sm_tready=0, D=1, stream 6 beats -> exactly 4 accepted, ss_tready low from cycle 5. sm_tready=1 then gives all 6 outputs in order with no duplicates.
- Change cfg_shift 0->4 mid-frame -> remaining outputs of the frame unshifted. Next frame uses shift 4. busy deasserts one cycle after the last output pops.
- Assert axis_rst after 3 beats of a 10-beat frame -> sm_tvalid=0, counters 0, busy 0. A new frame then processes normally.
